fifth_root_multi_cycle: RTL
===========================

// Module: fifth_root_multi_cycle
// PURPOSE
//  Inverse of the pow_5 datapath: accepts an unsigned x and returns r = floor(x^(1/5))
//  plus remainder x - r^5. Uses one shared multiplier, a bit-serial binary search and
//  an FSM, so it is multi-cycle.
//  Sits downstream of a pow_5 stage or a key/switch driven source in the pipeline labs.
//  Uses valid/ready flow control on both sides.
// PARAMETERS
//  width   12   bit width of x and of the remainder
//  root_w  derived localparam = (width + 4) / 5; bit width of r (3 for default)
// PORTS
//  clk        in   1        single clock; all flops on posedge
//  rst        in   1        synchronous, active-high reset
//  up_vld     in   1        x valid
//  up_rdy     out  1        block can accept x
//  up_data    in   width    x, unsigned
//  down_vld   out  1        result valid
//  down_rdy   in   1        consumer accepts result
//  down_root  out  root_w   r = floor(x^(1/5))
//  down_rem   out  width    x - r^5
// BEHAVIOUR
//  - Reset (rst high at posedge): state=IDLE; up_rdy=1; down_vld=0; down_root=0;
//    down_rem=0. Any in-flight operation is discarded, with no partial output.
//  - up_rdy = (state==IDLE), driven combinationally from the state register.
//  - Accept: posedge with up_vld & up_rdy. On that edge capture x, clear res,
//    set bit index b = root_w-1, go to LOAD.
//  - LOAD: cand = res | (1<<b); acc = cand (width 5*root_w, no overflow possible);
//    k = 0; go to MUL.
//  - MUL: acc <= acc * cand (truncated to 5*root_w bits); k++.
//    After 4 cycles acc = cand^5; go to CMP.
//  - CMP: if acc <= zero-extended x then res = cand and best = acc.
//    If b == 0 go to DONE, else b--, go to LOAD.
//  - Cost is 6 cycles per root bit. down_vld rises exactly 6*root_w posedges after
//    the accepting edge (18 for default width).
//  - DONE: down_vld=1; down_root=res; down_rem = x - best (best = 0 when res = 0).
//    Outputs are held stable while down_rdy=0.
//  - Posedge with down_vld & down_rdy returns to IDLE.
//    up_rdy stays low in DONE even when down_rdy=1, so there is one bubble cycle
//    and no overlap between results.
//  - down_root/down_rem keep their last values after the handshake.
//    Only down_vld qualifies them.
//  - up_vld while busy is ignored; up_data is not sampled.
//    Upstream must hold x until accepted.
//  - rst has priority over every transition, including the accept edge and the
//    down handshake edge.
// TESTING
//  - x=3125 -> root=5, rem=0. down_vld exactly 18 cycles after accept, and
//    up_rdy low meanwhile.
//  - Boundary values: x=0 -> 0/0; x=1 -> 1/0; x=31 -> 1/30; x=32 -> 2/0;
//    x=3124 -> 4/2100; x=4095 -> 5/970.
//  - Backpressure: down_rdy=0 for 10 cycles after down_vld. Outputs stable,
//    up_rdy=0. down_rdy=1 -> IDLE next edge, with a single bubble before the
//    next accept.
//  - Reset mid-operation: rst at cycle 7 of x=3125 -> next cycle up_rdy=1,
//    down_vld=0, outputs 0. A new x=243 -> 3/0.
//  - width=20 (root_w=4): x=1048575 -> root=15, rem=289200 after 24 cycles.
//  - Random: 1000 back-to-back x with random down_rdy; every result matches a
//    reference model (r^5 <= x < (r+1)^5).

Source files
------------

// File: rtl/fifth_root_multi_cycle_if.sv
// Valid/ready bundle for the fifth-root block.
//   up_vld/up_rdy/up_data       : operand x in, unsigned, width bits
//   down_vld/down_rdy           : result handshake
//   down_root                   : r = floor(x^(1/5)), root_w bits
//   down_rem                    : x - r^5, width bits
// slave modport is the block side, master modport is the producer/consumer side.
interface fifth_root_multi_cycle_if #(
    parameter int width = 12
);
    localparam int root_w = (width + 4) / 5;

    logic              up_vld;
    logic              up_rdy;
    logic [width-1:0]  up_data;
    logic              down_vld;
    logic              down_rdy;
    logic [root_w-1:0] down_root;
    logic [width-1:0]  down_rem;

    modport slave (
        input  up_vld, up_data, down_rdy,
        output up_rdy, down_vld, down_root, down_rem
    );

    modport master (
        output up_vld, up_data, down_rdy,
        input  up_rdy, down_vld, down_root, down_rem
    );
endinterface

// File: rtl/fifth_root_multi_cycle.sv
// Multi-cycle integer fifth root: r = floor(x^(1/5)), rem = x - r^5.
// Bit-serial binary search from the MSB of r; each candidate is raised to the
// fifth power with one shared multiplier over four cycles.
// Ports:
//   clk  : clock, all flops on posedge
//   rst  : synchronous active-high reset
//   bus  : valid/ready bundle (slave side), see fifth_root_multi_cycle_if
//
// state | meaning
// IDLE  | waiting for x, up_rdy high
// LOAD  | form candidate res | (1<<b), seed acc with it
// MUL   | acc *= cand, four passes give cand^5
// CMP   | keep candidate if cand^5 <= x, step to next bit or finish
// DONE  | result presented, held until down_rdy
module fifth_root_multi_cycle #(
    parameter int width = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    fifth_root_multi_cycle_if.slave  bus
);
    localparam int root_w = (width + 4) / 5;
    localparam int acc_w  = 5 * root_w;
    localparam int bidx_w = (root_w > 1) ? $clog2(root_w) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_CMP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [width-1:0]    r_x;
    logic [root_w-1:0]   r_res;
    logic [root_w-1:0]   r_cand;
    logic [acc_w-1:0]    r_acc;
    logic [acc_w-1:0]    r_best;
    logic [bidx_w-1:0]   r_b;
    logic [1:0]          r_k;
    logic [root_w-1:0]   r_root;
    logic [width-1:0]    r_rem;

    logic [root_w-1:0]   w_cand;
    logic                w_fits;
    logic [root_w-1:0]   w_final_root;
    logic [acc_w-1:0]    w_final_best;
    logic [acc_w-1:0]    w_x_ext;

    assign w_cand  = r_res | (root_w'(1) << r_b);
    assign w_x_ext = {{(acc_w - width){1'b0}}, r_x};
    assign w_fits  = (r_acc <= w_x_ext);

    // Outcome of the last CMP; best never exceeds x, so its low bits carry the full value.
    assign w_final_root = w_fits ? r_cand : r_res;
    assign w_final_best = w_fits ? r_acc  : r_best;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.up_vld) w_next = S_LOAD;
            S_LOAD:  w_next = S_MUL;
            S_MUL:   if (r_k == 2'd3) w_next = S_CMP;
            S_CMP:   w_next = (r_b == '0) ? S_DONE : S_LOAD;
            S_DONE:  if (bus.down_rdy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_res  <= '0;
            r_cand <= '0;
            r_acc  <= '0;
            r_best <= '0;
            r_b    <= '0;
            r_k    <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.up_vld) begin
                        r_x    <= bus.up_data;
                        r_res  <= '0;
                        r_best <= '0;
                        r_b    <= bidx_w'(root_w - 1);
                    end
                end
                S_LOAD: begin
                    r_cand <= w_cand;
                    r_acc  <= {{(acc_w - root_w){1'b0}}, w_cand};
                    r_k    <= '0;
                end
                S_MUL: begin
                    // cand < 2^root_w, so cand^5 fits in acc_w bits and truncation never bites.
                    r_acc <= r_acc * {{(acc_w - root_w){1'b0}}, r_cand};
                    r_k   <= r_k + 2'd1;
                end
                S_CMP: begin
                    if (w_fits) begin
                        r_res  <= r_cand;
                        r_best <= r_acc;
                    end
                    if (r_b == '0) begin
                        r_root <= w_final_root;
                        r_rem  <= r_x - w_final_best[width-1:0];
                    end else begin
                        r_b <= r_b - bidx_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.up_rdy    = (r_state == S_IDLE);
    assign bus.down_vld  = (r_state == S_DONE);
    assign bus.down_root = r_root;
    assign bus.down_rem  = r_rem;
endmodule
